// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  localparam int MAX_REQ = 4;
  // Requester index width, wide enough for MAX_REQ requesters.
  localparam int IDX_W   = 2;

  // Word index of a byte address.
  function automatic logic [29:0] word_idx(input logic [31:0] addr);
    return addr[31:2];
  endfunction

endpackage

// File: rtl/mem_arbiter_rr.sv
// Combinational round-robin pick: the first requester at or after ptr wins.
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_any
);

  // Scan priority offsets from ptr; the first valid candidate is granted.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int off = 0; off < N; off++) begin
      for (int i = 0; i < N; i++) begin
        if (!grant_any && req[i] && (((int'(ptr) + off) % N) == i)) begin
          grant[i]  = 1'b1;
          grant_idx = IDX_W'(i);
          grant_any = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer in front of the single-port data memory.
// One request is accepted at a time; the memory is driven for exactly one
// cycle (ACCESS) and a one-cycle response pulse follows (RESP).
// Optional build macro MEM_ARB_RANGE_CHK_EN: flags misaligned or out-of-range
// addresses; such requests never write and respond with rsp_err = 1.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int RAM_SIZE = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0]       req_write,
  input  logic [NUM_REQ-1:0][31:0] req_addr,
  input  logic [NUM_REQ-1:0][31:0] req_wdata,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [31:0]              rsp_rdata,
  output logic                     rsp_err,
  output logic                     mem_write,
  output logic [31:0]              mem_address,
  output logic [31:0]              mem_write_data,
  input  logic [31:0]              mem_read_data
);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             lat_write_q, lat_write_d;
  logic [31:0]      lat_addr_q, lat_addr_d;
  logic [31:0]      lat_wdata_q, lat_wdata_d;
  logic [IDX_W-1:0] lat_idx_q, lat_idx_d;
  logic             lat_err_q, lat_err_d;
  logic [31:0]      rsp_rdata_q, rsp_rdata_d;
  logic             rsp_err_q, rsp_err_d;

  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_any;
  logic               arb_en;
  logic               sel_write;
  logic [31:0]        sel_addr;
  logic [31:0]        sel_wdata;
  logic               sel_err;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // Arbitration is open in IDLE and RESP; held off while reset is asserted
  // so that req_ready reads 0 during reset even with requests pending.
  assign arb_en = rst_n && (state_q != ACCESS);

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign req_ready[gi] = arb_en && grant[gi];
    assign rsp_valid[gi] = (state_q == RESP) && (lat_idx_q == IDX_W'(gi));
  end

  // Mux the winning requester's fields onto a single set of latch inputs.
  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_write = req_write[i];
        sel_addr  = req_addr[i];
        sel_wdata = req_wdata[i];
      end
    end
  end

`ifdef MEM_ARB_RANGE_CHK_EN
  assign sel_err = (sel_addr[1:0] != 2'b00) || (word_idx(sel_addr) >= 30'(RAM_SIZE));
`else
  assign sel_err = 1'b0;
`endif

  // Next-state logic: accept in IDLE/RESP, access for one cycle, then respond.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    lat_write_d = lat_write_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    lat_idx_d   = lat_idx_q;
    lat_err_d   = lat_err_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE, RESP: begin
        if (grant_any) begin
          state_d     = ACCESS;
          lat_write_d = sel_write;
          lat_addr_d  = sel_addr;
          lat_wdata_d = sel_wdata;
          lat_idx_d   = grant_idx;
          lat_err_d   = sel_err;
          if (int'(grant_idx) == NUM_REQ - 1) rr_ptr_d = '0;
          else                                rr_ptr_d = grant_idx + IDX_W'(1);
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        state_d     = RESP;
        // Writes and flagged requests return zero data.
        rsp_rdata_d = (lat_write_q || lat_err_q) ? 32'h0 : mem_read_data;
        rsp_err_d   = lat_err_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pointer, request latches and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      lat_write_q <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      lat_idx_q   <= '0;
      lat_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      lat_write_q <= lat_write_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
      lat_idx_q   <= lat_idx_d;
      lat_err_q   <= lat_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Memory ports are only non-zero during ACCESS; reset drops them at once.
  assign mem_write      = (state_q == ACCESS) && lat_write_q && !lat_err_q;
  assign mem_address    = (state_q == ACCESS) ? lat_addr_q  : 32'h0;
  assign mem_write_data = (state_q == ACCESS) ? lat_wdata_q : 32'h0;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_err        = rsp_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a response scoreboard and memory model.
module tb_mem_arbiter;

  localparam int NUM_REQ  = 2;
  localparam int RAM_SIZE = 256;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_write;
  logic [NUM_REQ-1:0][31:0] req_addr;
  logic [NUM_REQ-1:0][31:0] req_wdata;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [31:0]              rsp_rdata;
  logic                     rsp_err;
  logic                     mem_write;
  logic [31:0]              mem_address;
  logic [31:0]              mem_write_data;
  logic [31:0]              mem_read_data;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  mem_arbiter #(.NUM_REQ(NUM_REQ), .RAM_SIZE(RAM_SIZE)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_write      (req_write),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_ready      (req_ready),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .rsp_err        (rsp_err),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // Memory: combinational read, write on rising edge.
  logic [31:0] mem [RAM_SIZE] = '{default: 32'h0};
  assign mem_read_data = mem[mem_address[9:2]];
  always @(posedge clk) if (mem_write) mem[mem_address[9:2]] <= mem_write_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: accepted requests queued, responses compared against a
  // reference memory that is updated when a write is acknowledged.
  typedef struct {
    int          idx;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          cyc;
  } txn_t;

  txn_t        sb[$];
  logic [31:0] ref_mem [RAM_SIZE] = '{default: 32'h0};

  always @(negedge clk) begin : monitor
    txn_t        t;
    logic        err;
    logic [31:0] exp_rd;
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (rsp_valid != '0) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 32'(rsp_valid), 32'h0);
        end else begin
          t   = sb.pop_front();
          err = 1'b0;
`ifdef MEM_ARB_RANGE_CHK_EN
          err = (t.addr[1:0] != 2'b00) || (t.addr[31:2] >= 30'(RAM_SIZE));
`endif
          if (err) exp_rd = 32'h0;
          else if (t.wr) begin
            exp_rd = 32'h0;
            ref_mem[t.addr[9:2]] = t.wdata;
          end else exp_rd = ref_mem[t.addr[9:2]];
          check("sb_rsp_valid", 32'(rsp_valid), 32'(1 << t.idx));
          check("sb_rdata", rsp_rdata, exp_rd);
          check("sb_err", 32'(rsp_err), 32'(err));
          check("sb_latency", 32'(cycle - t.cyc), 32'd2);
          $display("rsp: req%0d %s addr=%h rdata=%h err=%0d", t.idx, t.wr ? "WR" : "RD",
                   t.addr, rsp_rdata, rsp_err);
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          sb.push_back('{i, req_write[i], req_addr[i], req_wdata[i], cycle});
          $display("hs:  req%0d %s addr=%h wdata=%h cycle=%0d", i, req_write[i] ? "WR" : "RD",
                   req_addr[i], req_wdata[i], cycle);
        end
      end
    end
  end

  task automatic drv(input int i, input logic v, input logic w, input logic [31:0] a,
                     input logic [31:0] d);
    req_valid[i] = v;
    req_write[i] = w;
    req_addr[i]  = a;
    req_wdata[i] = d;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Single write from req0 starting in IDLE; checks the memory strobe and response.
  task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                          input logic exp_mw, input logic exp_err);
    next(); drv(0, 1'b1, 1'b1, a, d);
    smp();  check({tag, "_ready"}, 32'(req_ready), 32'h1);
    next(); drv(0, 1'b0, 1'b0, 32'h0, 32'h0);
    smp();  check({tag, "_mem_write"}, 32'(mem_write), 32'(exp_mw));
    next();
    smp();  check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h1);
            check({tag, "_rsp_err"}, 32'(rsp_err), 32'(exp_err));
            check({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
            check({tag, "_mem_write_resp"}, 32'(mem_write), 32'h0);
  endtask

  initial begin
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    rst_n = 1'b0;
    repeat (2) smp();
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err", 32'(rsp_err), 32'h0);
    check("rst_mem_write", 32'(mem_write), 32'h0);
    check("rst_mem_address", mem_address, 32'h0);
    check("rst_mem_wdata", mem_write_data, 32'h0);

    // Write 0xDEADBEEF to 0x10, then read it back.
    next(); rst_n = 1'b1; drv(0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
    smp();  check("t1_wr_ready", 32'(req_ready), 32'h1);
            check("t1_wr_mw_T", 32'(mem_write), 32'h0);
    next(); drv(0, 1'b0, 1'b0, 32'h0, 32'h0);
    smp();  check("t1_wr_mw_T1", 32'(mem_write), 32'h1);
            check("t1_wr_addr", mem_address, 32'h10);
            check("t1_wr_data", mem_write_data, 32'hDEADBEEF);
            check("t1_wr_norsp", 32'(rsp_valid), 32'h0);
    next(); drv(0, 1'b1, 1'b0, 32'h10, 32'h0);
    smp();  check("t1_wr_rsp", 32'(rsp_valid), 32'h1);
            check("t1_wr_mw_T2", 32'(mem_write), 32'h0);
            check("t1_rd_ready", 32'(req_ready), 32'h1);
    next(); drv(0, 1'b0, 1'b0, 32'h0, 32'h0);
    smp();  check("t1_rd_mw", 32'(mem_write), 32'h0);
            check("t1_rd_addr", mem_address, 32'h10);
    next();
    smp();  check("t1_rd_rsp", 32'(rsp_valid), 32'h1);
            check("t1_rd_data", rsp_rdata, 32'hDEADBEEF);

    // Contention: both requesters valid from reset; grants alternate 0,1,0,1.
    next(); rst_n = 1'b0;
    drv(0, 1'b1, 1'b0, 32'h10, 32'h0);
    drv(1, 1'b1, 1'b0, 32'h14, 32'h0);
    smp();  check("t2_rst_ready", 32'(req_ready), 32'h0);
    next(); rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      smp();
      check($sformatf("t2_ready_c%0d", k), 32'(req_ready),
            (k % 4 == 0) ? 32'h1 : ((k % 4 == 2) ? 32'h2 : 32'h0));
    end
    next(); drv(0, 1'b0, 1'b0, 32'h0, 32'h0); drv(1, 1'b0, 1'b0, 32'h0, 32'h0);
    smp();  check("t2_last_rsp", 32'(rsp_valid), 32'h2);

    // Back-to-back: req1 alone issues four reads.
    next(); drv(1, 1'b1, 1'b0, 32'h10, 32'h0);
    for (int k = 0; k < 8; k++) begin
      smp();
      check($sformatf("t3_ready_c%0d", k), 32'(req_ready), (k % 2 == 0) ? 32'h2 : 32'h0);
      check($sformatf("t3_rsp_c%0d", k), 32'(rsp_valid),
            (k >= 2 && k % 2 == 0) ? 32'h2 : 32'h0);
      next();
      if (k == 6) drv(1, 1'b0, 1'b0, 32'h0, 32'h0);
      else if (k % 2 == 0) drv(1, 1'b1, 1'b0, 32'h10 + 32'(4 * (k / 2 + 1)), 32'h0);
    end
    smp();  check("t3_rsp_c8", 32'(rsp_valid), 32'h2);

    // Reset during ACCESS of a write to 0x20.
    next(); drv(0, 1'b1, 1'b1, 32'h20, 32'h12345678);
    smp();  check("t4_ready", 32'(req_ready), 32'h1);
    next(); drv(0, 1'b0, 1'b0, 32'h0, 32'h0);
    smp();  check("t4_mw_access", 32'(mem_write), 32'h1);
    #2 rst_n = 1'b0;
    #1 check("t4_mw_dropped", 32'(mem_write), 32'h0);
       check("t4_addr_dropped", mem_address, 32'h0);
    smp();  check("t4_no_rsp_a", 32'(rsp_valid), 32'h0);
    next(); rst_n = 1'b1;
    drv(0, 1'b1, 1'b0, 32'h20, 32'h0);
    drv(1, 1'b1, 1'b0, 32'h20, 32'h0);
    smp();  check("t4_no_rsp_b", 32'(rsp_valid), 32'h0);
            check("t4_ptr_zero", 32'(req_ready), 32'h1);
    next(); drv(0, 1'b0, 1'b0, 32'h0, 32'h0); drv(1, 1'b0, 1'b0, 32'h0, 32'h0);
    smp();
    next();
    smp();  check("t4_rd_rsp", 32'(rsp_valid), 32'h1);
            check("t4_rd_data", rsp_rdata, 32'h0);

    // Top word of the memory is a legal target in every build.
    do_write("t5_3fc", 32'h3FC, 32'hCAFEF00D, 1'b1, 1'b0);
`ifdef MEM_ARB_RANGE_CHK_EN
    do_write("t6_402", 32'h402, 32'hAAAA5555, 1'b0, 1'b1);
    do_write("t6_400", 32'h400, 32'h5555AAAA, 1'b0, 1'b1);
`endif
    // Read back 0x3FC; the scoreboard holds the expected value.
    next(); drv(0, 1'b1, 1'b0, 32'h3FC, 32'h0);
    smp();  check("t7_ready", 32'(req_ready), 32'h1);
    next(); drv(0, 1'b0, 1'b0, 32'h0, 32'h0);
    smp();
    next();
    smp();  check("t7_rd_data", rsp_rdata, 32'hCAFEF00D);

    repeat (3) smp();
    check("sb_empty", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
